// File: rtl/liteic_slave_node_write_arb.sv
// Round-robin write-path arbiter for one slave slot: forwards AW/W of the locked grant, returns B to it.
// Optional B-timeout with orphan-response absorption is enabled by defining LITEIC_WR_ARB_TIMEOUT_EN.

module liteic_slave_node_write_arb #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned WDATA_WIDTH    = 36,
  parameter int unsigned BRESP_WIDTH    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic [NUM_MASTERS-1:0]              aw_val_i,
  output logic [NUM_MASTERS-1:0]              aw_rdy_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   aw_data_i,
  input  logic [NUM_MASTERS-1:0]              w_val_i,
  output logic [NUM_MASTERS-1:0]              w_rdy_o,
  input  logic [NUM_MASTERS*WDATA_WIDTH-1:0]  w_data_i,
  output logic [NUM_MASTERS-1:0]              b_val_o,
  input  logic [NUM_MASTERS-1:0]              b_rdy_i,
  output logic [BRESP_WIDTH-1:0]              b_data_o,
  output logic [ADDR_WIDTH-1:0]               s_aw_addr_o,
  output logic                                s_aw_valid_o,
  input  logic                                s_aw_ready_i,
  output logic [WDATA_WIDTH-1:0]              s_w_data_o,
  output logic                                s_w_valid_o,
  input  logic                                s_w_ready_i,
  input  logic [BRESP_WIDTH-1:0]              s_b_resp_i,
  input  logic                                s_b_valid_i,
  output logic                                s_b_ready_o
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [BRESP_WIDTH-1:0] RESP_SLVERR = BRESP_WIDTH'(2);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("liteic_slave_node_write_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                   r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic                     r_aw_done, w_aw_done_nxt;
  logic                     r_w_done, w_w_done_nxt;
  logic                     w_found;
  logic [IDX_W-1:0]         w_scan;
  logic [IDX_W-1:0]         w_win_idx;
  logic [IDX_W-1:0]         w_gnt_idx;
  logic [ADDR_WIDTH-1:0]    w_sel_addr;
  logic [WDATA_WIDTH-1:0]   w_sel_wdata;
  logic                     w_release;
  logic                     w_timed_out;
  logic                     w_orphan;

  // Round-robin pick over AW requests, starting at r_rr_ptr and wrapping
  always_comb begin : arb_comb
    w_found   = 1'b0;
    w_scan    = '0;
    w_win_idx = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      w_scan = IDX_W'((32'(r_rr_ptr) + k) % NUM_MASTERS);
      if (!w_found && aw_val_i[w_scan]) begin
        w_found   = 1'b1;
        w_win_idx = w_scan;
      end
    end
  end

  // Granted index and payload mux (grant is one-hot or zero)
  always_comb begin : sel_comb
    w_gnt_idx   = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_gnt_idx   = IDX_W'(k);
        w_sel_addr  = aw_data_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = w_data_i[k*WDATA_WIDTH +: WDATA_WIDTH];
      end
    end
  end

  // Next state and slot-side/master-side handshake outputs
  always_comb begin : fsm_comb
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_release     = 1'b0;
    aw_rdy_o      = '0;
    w_rdy_o       = '0;
    b_val_o       = '0;
    b_data_o      = '0;
    s_aw_valid_o  = 1'b0;
    s_w_valid_o   = 1'b0;
    s_b_ready_o   = w_orphan;
    s_aw_addr_o   = w_sel_addr;
    s_w_data_o    = w_sel_wdata;

    case (r_state)
      IDLE: begin
        if (w_found && !w_orphan) begin
          w_grant_nxt = NUM_MASTERS'(1) << w_win_idx;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        s_aw_valid_o  = (|(aw_val_i & r_grant)) & ~r_aw_done;
        s_w_valid_o   = (|(w_val_i & r_grant)) & ~r_w_done;
        aw_rdy_o      = (s_aw_ready_i && !r_aw_done) ? r_grant : '0;
        w_rdy_o       = (s_w_ready_i && !r_w_done) ? r_grant : '0;
        w_aw_done_nxt = r_aw_done | (s_aw_valid_o & s_aw_ready_i);
        w_w_done_nxt  = r_w_done | (s_w_valid_o & s_w_ready_i);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_timed_out) begin
          // Synthesised SLVERR; the slave's eventual B is absorbed later
          b_val_o   = r_grant;
          b_data_o  = RESP_SLVERR;
          w_release = |(b_rdy_i & r_grant);
        end else begin
          s_b_ready_o = |(b_rdy_i & r_grant);
          b_val_o     = s_b_valid_i ? r_grant : '0;
          b_data_o    = s_b_resp_i;
          w_release   = s_b_valid_i & s_b_ready_o;
        end
        if (w_release) begin
          w_rr_ptr_nxt  = IDX_W'((32'(w_gnt_idx) + 32'd1) % NUM_MASTERS);
          w_grant_nxt   = '0;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin : state_ff
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

`ifdef LITEIC_WR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_orphan;

  assign w_timed_out = (r_state == RESP) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign w_orphan    = r_orphan;

  // B wait counter and orphan flag for a response the master already got as SLVERR
  always_ff @(posedge clk_i or negedge rstn_i) begin : timeout_ff
    if (!rstn_i) begin
      r_to_cnt <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (r_state != RESP) begin
        r_to_cnt <= '0;
      end else if (!w_timed_out && !w_release) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_timed_out && w_release) begin
        r_orphan <= 1'b1;
      end else if (r_orphan && s_b_valid_i) begin
        r_orphan <= 1'b0;
      end
    end
  end
`else
  assign w_timed_out = 1'b0;
  assign w_orphan    = 1'b0;
`endif

endmodule

// File: tb/tb_liteic_slave_node_write_arb.sv
// Scoreboard bench for liteic_slave_node_write_arb (default build, 4 masters).

module tb_liteic_slave_node_write_arb;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned WW = 36;
  localparam int unsigned BW = 2;

  logic             clk;
  logic             rstn;
  logic [NM-1:0]    aw_val, aw_rdy, w_val, w_rdy, b_val, b_rdy;
  logic [NM*AW-1:0] aw_data;
  logic [NM*WW-1:0] w_data;
  logic [BW-1:0]    b_data, s_b_resp;
  logic [AW-1:0]    s_aw_addr;
  logic [WW-1:0]    s_w_data;
  logic             s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;

  typedef struct packed {
    logic [NM-1:0] gnt;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic [BW-1:0] resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  liteic_slave_node_write_arb dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .aw_val_i     (aw_val),
    .aw_rdy_o     (aw_rdy),
    .aw_data_i    (aw_data),
    .w_val_i      (w_val),
    .w_rdy_o      (w_rdy),
    .w_data_i     (w_data),
    .b_val_o      (b_val),
    .b_rdy_i      (b_rdy),
    .b_data_o     (b_data),
    .s_aw_addr_o  (s_aw_addr),
    .s_aw_valid_o (s_aw_valid),
    .s_aw_ready_i (s_aw_ready),
    .s_w_data_o   (s_w_data),
    .s_w_valid_o  (s_w_valid),
    .s_w_ready_i  (s_w_ready),
    .s_b_resp_i   (s_b_resp),
    .s_b_valid_i  (s_b_valid),
    .s_b_ready_o  (s_b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    aw_val = '0; aw_data = '0; w_val = '0; w_data = '0; b_rdy = '0;
    s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_resp = '0; s_b_valid = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [WW-1:0] d);
    aw_val[m] = 1'b1;
    aw_data[m*AW +: AW] = a;
    w_val[m] = 1'b1;
    w_data[m*WW +: WW] = d;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    aw_val = '1; aw_data = '1; w_val = '1; w_data = '1; b_rdy = '1;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_resp = '1; s_b_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({aw_rdy, w_rdy, b_val} !== '0) begin
      n_errors++; $display("FAIL reset_master_side got=%h exp=0", {aw_rdy, w_rdy, b_val});
    end
    n_checks++;
    if ({s_aw_valid, s_w_valid, s_b_ready} !== 3'b000) begin
      n_errors++; $display("FAIL reset_slave_ctrl got=%b exp=000", {s_aw_valid, s_w_valid, s_b_ready});
    end
    n_checks++;
    if ({b_data, s_aw_addr, s_w_data} !== '0) begin
      n_errors++; $display("FAIL reset_payloads got=%h exp=0", {b_data, s_aw_addr, s_w_data});
    end
    clear_inputs();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s_aw_valid, s_w_valid, b_val} !== '0) begin
        n_errors++; $display("FAIL idle_no_valid cyc=%0d got=%h exp=0", i, {s_aw_valid, s_w_valid, b_val});
      end
    end
  endtask

  task automatic test_round_robin();
    int   order [5] = '{0, 1, 2, 3, 0};
    exp_t e;
    bit   found;
    bit   stray;
    tick();
    clear_inputs();
    for (int m = 0; m < int'(NM); m++) set_req(m, AW'(32'h10 + m), {4'h3, 32'hC0DE_0000 + 32'(m)});
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1; s_b_resp = 2'b01; b_rdy = '1;
    for (int t = 0; t < 5; t++)
      exp_q.push_back('{gnt: NM'(1) << order[t], addr: AW'(32'h10 + order[t]),
                        data: {4'h3, 32'hC0DE_0000 + 32'(order[t])}, resp: 2'b01});
    stray = 1'b0;
    for (int t = 0; t < 5; t++) begin
      e = exp_q.pop_front();
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        @(negedge clk);
        if (s_aw_valid === 1'b1) found = 1'b1;
        else if ((aw_rdy | w_rdy) !== '0) stray = 1'b1;
      end
      n_checks++;
      if (!found) begin
        n_errors++; $display("FAIL rr_wait txn=%0d got=no_aw_valid exp=aw_valid within 8 cycles", t);
      end else begin
        n_checks++;
        if ({s_w_valid, s_aw_addr, s_w_data} !== {1'b1, e.addr, e.data}) begin
          n_errors++; $display("FAIL rr_payload txn=%0d got=%b/%h/%h exp=1/%h/%h",
                               t, s_w_valid, s_aw_addr, s_w_data, e.addr, e.data);
        end
        n_checks++;
        if (aw_rdy !== e.gnt || w_rdy !== e.gnt) begin
          n_errors++; $display("FAIL rr_grant txn=%0d got aw_rdy=%b w_rdy=%b exp=%b", t, aw_rdy, w_rdy, e.gnt);
        end
        @(negedge clk);
        if ((aw_rdy | w_rdy) !== '0) stray = 1'b1;
        n_checks++;
        if (b_val !== e.gnt || b_data !== e.resp || s_b_ready !== 1'b1) begin
          n_errors++; $display("FAIL rr_bresp txn=%0d got=%b/%b/%b exp=%b/%b/1", t, b_val, b_data, s_b_ready, e.gnt, e.resp);
        end
      end
    end
    n_checks++;
    if (stray) begin
      n_errors++; $display("FAIL rr_nongranted_ready got=ready outside grant exp=0");
    end
    tick();
    clear_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_aw_valid, b_val} !== '0) begin
      n_errors++; $display("FAIL rr_drain got=%h exp=0", {s_aw_valid, b_val});
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    tick();
    clear_inputs();
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    set_req(2, 8'h34, 36'h0_DEAD_BEEF);
    exp_q.push_back('{gnt: 4'b0100, addr: 8'h34, data: 36'h0_DEAD_BEEF, resp: 2'b00});
    @(negedge clk);
    n_checks++;
    if (s_aw_valid !== 1'b0 || aw_rdy !== '0) begin
      n_errors++; $display("FAIL single_idle_latency got=%b/%b exp=0/0000", s_aw_valid, aw_rdy);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({s_aw_valid, s_w_valid, s_aw_addr, s_w_data} !== {2'b11, e.addr, e.data}) begin
      n_errors++; $display("FAIL single_fwd got=%b%b/%h/%h exp=11/%h/%h", s_aw_valid, s_w_valid, s_aw_addr, s_w_data, e.addr, e.data);
    end
    n_checks++;
    if (aw_rdy !== e.gnt || w_rdy !== e.gnt) begin
      n_errors++; $display("FAIL single_ready got=%b/%b exp=%b", aw_rdy, w_rdy, e.gnt);
    end
    tick();
    aw_val = '0; w_val = '0;
    s_b_valid = 1'b1; s_b_resp = 2'b00; b_rdy = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (b_val !== e.gnt || b_data !== e.resp || s_b_ready !== 1'b1) begin
      n_errors++; $display("FAIL single_bresp got=%b/%b/%b exp=%b/%b/1", b_val, b_data, s_b_ready, e.gnt, e.resp);
    end
    tick();
    s_b_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b_val, s_aw_valid, s_b_ready} !== '0) begin
      n_errors++; $display("FAIL single_back_idle got=%b/%b/%b exp=0", b_val, s_aw_valid, s_b_ready);
    end
  endtask

  task automatic test_split_order();
    exp_t e;
    int   aw_hs, w_hs, w_at_aw;
    bit   early;
    for (int part = 0; part < 2; part++) begin
      tick();
      clear_inputs();
      set_req(1, AW'(8'h5A + part), 36'h9_1234_5670 + 36'(part));
      s_aw_ready = (part == 1); s_w_ready = 1'b1; b_rdy = 4'b0010;
      exp_q.push_back('{gnt: 4'b0010, addr: AW'(8'h5A + part), data: 36'h9_1234_5670 + 36'(part), resp: 2'b00});
      e = exp_q.pop_front();
      aw_hs = 0; w_hs = 0; w_at_aw = -1; early = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
        @(negedge clk);
        if (s_b_ready === 1'b1 && (aw_hs == 0 || w_hs == 0)) early = 1'b1;
        if (s_w_valid === 1'b1 && s_w_ready) w_hs++;
        if (s_aw_valid === 1'b1 && s_aw_ready) begin
          aw_hs++;
          w_at_aw = w_hs;
          n_checks++;
          if (s_aw_addr !== e.addr) begin
            n_errors++; $display("FAIL split_addr part=%0d got=%h exp=%h", part, s_aw_addr, e.addr);
          end
        end
        tick();
        if (cyc == 4) s_aw_ready = 1'b1;
        if (aw_hs > 0 && w_hs > 0) begin aw_val = '0; w_val = '0; end
      end
      n_checks++;
      if (aw_hs != 1 || w_hs != 1) begin
        n_errors++; $display("FAIL split_hs_count part=%0d got aw=%0d w=%0d exp=1/1", part, aw_hs, w_hs);
      end
      n_checks++;
      if (early || s_b_ready !== 1'b1) begin
        n_errors++; $display("FAIL split_resp_entry part=%0d got early=%b s_b_ready=%b exp=0/1", part, early, s_b_ready);
      end
      n_checks++;
      if (w_at_aw != 1) begin
        n_errors++; $display("FAIL split_w_before_aw part=%0d got w_hs_at_aw=%0d exp=1", part, w_at_aw);
      end
      s_b_valid = 1'b1; s_b_resp = e.resp;
      @(negedge clk);
      n_checks++;
      if (b_val !== e.gnt || b_data !== e.resp) begin
        n_errors++; $display("FAIL split_bresp part=%0d got=%b/%b exp=%b/%b", part, b_val, b_data, e.gnt, e.resp);
      end
      tick();
      clear_inputs();
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    bit   found;
    tick();
    clear_inputs();
    set_req(0, 8'hC3, 36'h1_1111_1111);
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_aw_valid !== 1'b1 || s_aw_addr !== 8'hC3) begin
      n_errors++; $display("FAIL mid_pre_reset got=%b/%h exp=1/c3", s_aw_valid, s_aw_addr);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({aw_rdy, w_rdy, b_val, s_aw_valid, s_w_valid, s_b_ready, s_aw_addr, s_w_data, b_data} !== '0) begin
      n_errors++; $display("FAIL mid_reset_outputs got=%b/%b/%b/%b%b%b exp=0",
                           aw_rdy, w_rdy, b_val, s_aw_valid, s_w_valid, s_b_ready);
    end
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({aw_rdy, w_rdy, s_aw_valid} !== '0) begin
      n_errors++; $display("FAIL mid_reset_hold got=%b/%b/%b exp=0", aw_rdy, w_rdy, s_aw_valid);
    end
    clear_inputs();
    exp_q.delete();
    tick();
    rstn = 1'b1;
    set_req(1, 8'h11, 36'h2_0000_0011);
    set_req(3, 8'h33, 36'h2_0000_0033);
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    exp_q.push_back('{gnt: 4'b0010, addr: 8'h11, data: 36'h2_0000_0011, resp: 2'b01});
    e = exp_q.pop_front();
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (s_aw_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || aw_rdy !== e.gnt || s_aw_addr !== e.addr) begin
      n_errors++; $display("FAIL mid_rr_restart got=%b/%b/%h exp=1/%b/%h", found, aw_rdy, s_aw_addr, e.gnt, e.addr);
    end
    tick();
    aw_val = '0; w_val = '0;
    s_b_valid = 1'b1; s_b_resp = e.resp; b_rdy = '1;
    @(negedge clk);
    n_checks++;
    if (b_val !== e.gnt || b_data !== e.resp) begin
      n_errors++; $display("FAIL mid_bresp got=%b/%b exp=%b/%b", b_val, b_data, e.gnt, e.resp);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_b_backpressure();
    exp_t e;
    bit   found;
    tick();
    clear_inputs();
    set_req(3, 8'h7E, 36'hF_0000_0001);
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    exp_q.push_back('{gnt: 4'b1000, addr: 8'h7E, data: 36'hF_0000_0001, resp: 2'b10});
    e = exp_q.pop_front();
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (s_aw_valid === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found || aw_rdy !== e.gnt || s_w_data !== e.data) begin
      n_errors++; $display("FAIL bp_xfer got=%b/%b/%h exp=1/%b/%h", found, aw_rdy, s_w_data, e.gnt, e.data);
    end
    tick();
    aw_val = '0; w_val = '0;
    s_b_valid = 1'b1; s_b_resp = 2'b10; b_rdy = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({b_val, b_data, s_b_ready} !== {e.gnt, e.resp, 1'b0}) begin
        n_errors++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%b exp=%b/%b/0", i, b_val, b_data, s_b_ready, e.gnt, e.resp);
      end
    end
    tick();
    b_rdy = 4'b1111;
    @(negedge clk);
    n_checks++;
    if ({b_val, b_data, s_b_ready} !== {e.gnt, e.resp, 1'b1}) begin
      n_errors++; $display("FAIL bp_accept got=%b/%b/%b exp=%b/%b/1", b_val, b_data, s_b_ready, e.gnt, e.resp);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (b_val !== '0 || s_b_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_release got=%b/%b exp=0000/0", b_val, s_b_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_single_write();
    test_split_order();
    test_reset_midflight();
    test_b_backpressure();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
